ins_exec_mc: RTL and testbench
==============================

# ins_exec_mc

Multi-cycle, parametrised RV32I/RV32M execute stage that sits between the instruction decoder/register read stage and register/PC/memory writeback. It accepts one decoded instruction at a time through a valid/ready handshake. Simple ops execute in one cycle, loads and stores run a request/acknowledge handshake with data memory, and DIV/DIVU/REM/REMU run on an iterative divider. Results leave as one-cycle writeback pulses.

## Interface
Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64. At 64, byte lanes scale and only RV32 opcodes are decoded.
- ENABLE_M, 1, enables the M extension. When 0, funct7=0000001 under op 0110011 is illegal.
- DIV_RADIX_BITS, 1, quotient bits retired per divider cycle; legal values are 1 and 2.

Ports:
- sys_clk  in  1  clock; all state updates on posedge.
- sys_rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  decoded instruction is valid.
- in_ready  out  1  block can accept an instruction.
- ins_dec_op / ins_dec_funct3 / ins_dec_funct7  in  7/3/7  decoded opcode fields.
- reg_rs1_val, reg_rs2_val, reg_pc_val, imm_ext_ext  in  XLEN  operands, PC and sign-extended immediate.
- reg_rd  in  5  destination register index.
- mem_req  out  1  memory request, held until acknowledged.
- mem_we  out  1  request is a store.
- mem_addr  out  XLEN  word-aligned address (low log2(XLEN/8) bits are zero).
- mem_wdata  out  XLEN  lane-shifted store data.
- mem_wstrb  out  XLEN/8  byte enables.
- mem_ack  in  1  request complete; mem_rdata is valid in the same cycle.
- mem_rdata  in  XLEN  load data word.
- reg_w_op  out  1  register write pulse.
- reg_w_reg_idx  out  5  register write index.
- reg_w_reg_val  out  XLEN  register write data.
- reg_pc_w_op  out  1  PC redirect pulse.
- reg_pc_w_val  out  XLEN  PC redirect target.
- exc_op  out  1  exception pulse.
- exc_cause  out  2  exception cause: 0 = illegal, 1 = load misaligned, 2 = store misaligned.

## Operation
- FSM states: IDLE, MEM, DIV, WB.
- in_ready = (state == IDLE). An instruction is accepted when in_valid && in_ready. All inputs are captured into internal registers on acceptance.
- IDLE → WB for R-type, I-comp, LUI, AUIPC, JAL, JALR, branches, MUL*, and illegal instructions. The result is computed from the captured operands.
- IDLE → MEM for loads and stores whose address is aligned. Address = rs1 + imm.
- IDLE → WB with exc_op for misaligned accesses: halfword requires addr[0] = 0; word requires addr[1:0] = 0.
- MEM:
  - mem_req = 1. mem_addr, mem_we, mem_wdata and mem_wstrb stay stable until mem_ack.
  - On mem_ack, a load extracts its byte/halfword/word by address offset and sign- or zero-extends it according to funct3, then the FSM goes to WB.
- DIV:
  - Restoring divider on operand magnitudes, XLEN/DIV_RADIX_BITS iterations, then sign fix-up, then WB.
  - Divide-by-zero: quotient is all ones and remainder is the dividend, both resolved at entry with zero iterations.
  - Signed overflow (most negative value / −1): quotient is the dividend and remainder is 0, also with zero iterations.
- WB: exactly one cycle of output pulses, then IDLE.
  - reg_w_op is suppressed when rd = 0.
  - JAL and JALR write pc+4 and redirect. The JALR target has bit 0 cleared.
  - A taken branch redirects to pc+imm. A not-taken branch produces no pulse.
  - Stores produce no register write.
- Shifts use shamt = low 5 bits of the operand. Arithmetic wraps modulo 2^XLEN. MULH, MULHSU and MULHU return the upper XLEN bits of the 2·XLEN product.
- All outputs are zero whenever they are not pulsing.

## Timing
- Reset values: in_ready = 1 (once reset deasserts); every other output = 0; state = IDLE.
- Latency from acceptance to WB pulse:
  - ALU, branch and jump: 1 cycle.
  - Memory: 1 + cycles until mem_ack (a minimum of 2 total).
  - Divide: 2 + XLEN/DIV_RADIX_BITS cycles.
  - Divide special cases: 2 cycles.
- mem_req can assert in the cycle after acceptance at the earliest. An ack in that same cycle is legal.
- mem_ack outside MEM is ignored.
- in_valid while in_ready = 0 is not consumed. The producer holds its instruction.
- Reset asserted mid-MEM or mid-DIV: the next cycle has mem_req = 0, no writeback pulse, and state IDLE. A late mem_ack is ignored.
- Throughput is at most one instruction per 2 cycles, because the WB cycle has in_ready = 0.

## Structure
- A shared package holds:
  - opcode constants: OP_R, OP_I_COMP, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC;
  - the funct3 encodings;
  - the exception cause enum;
  - the FSM state enum.
- One sub-module: ins_exec_div. It is the iterative divider with a start/done handshake, parametrised by XLEN and DIV_RADIX_BITS.

## Test plan
- ADD x5 with rs1=0x7FFFFFFF, rs2=1 → WB cycle after accept: reg_w_op=1, idx=5, val=0x80000000. Repeat with rd=0 → reg_w_op stays 0.
- LB at addr 0x103 with mem_rdata=0x80FF_0000 and mem_ack delayed 3 cycles → mem_addr=0x100 held stable for 3 cycles; then reg_w_reg_val=0xFFFFFF80. LBU of the same byte gives 0x00000080.
- SH of rs2=0x1234 to addr 0x202 → mem_wstrb=4'b1100, mem_wdata=0x12340000, mem_we=1. SH to 0x201 → exc_op=1, exc_cause=2, no mem_req.
- DIV −7/2 → quotient −3 after 34 cycles (XLEN=32, radix 1). REM −7/2 → −1. DIVU 5/0 → 0xFFFFFFFF in 2 cycles. DIV 0x80000000/−1 → 0x80000000.
- BEQ taken from pc=0x40 with imm=−8 → reg_pc_w_op=1, val=0x38. JALR rs1=0x101, imm=0 → target 0x100, rd gets 0x44.
- sys_rst_n low during DIV iteration 10 and during MEM wait → the next cycle has mem_req=0, in_ready=1 and no pulses. A subsequent ADD completes normally.

Source files
------------

// File: rtl/ins_exec_mc_pkg.sv
// rtl/ins_exec_mc_pkg.sv - shared opcode, funct3/funct7, exception and state definitions
package ins_exec_mc_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_COMP = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL  = 3'd1, F3_SLT  = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4, F3_SR   = 3'd5, F3_OR   = 3'd6, F3_AND  = 3'd7;
  localparam logic [2:0] F3_MUL  = 3'd0, F3_MULH = 3'd1, F3_MULHSU = 3'd2, F3_MULHU = 3'd3;
  localparam logic [2:0] F3_DIV  = 3'd4, F3_DIVU = 3'd5, F3_REM  = 3'd6, F3_REMU = 3'd7;
  localparam logic [2:0] F3_LB   = 3'd0, F3_LH   = 3'd1, F3_LW   = 3'd2, F3_LBU  = 3'd4, F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB   = 3'd0, F3_SH   = 3'd1, F3_SW   = 3'd2;
  localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE  = 3'd1, F3_BLT  = 3'd4, F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6, F3_BGEU = 3'd7;

  typedef enum logic [1:0] {
    EXC_ILLEGAL        = 2'd0,
    EXC_LOAD_MISALIGN  = 2'd1,
    EXC_STORE_MISALIGN = 2'd2
  } exc_cause_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_DIV  = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/ins_exec_mc_if.sv
// rtl/ins_exec_mc_if.sv - data memory request/acknowledge bus
interface ins_exec_mc_if #(
  parameter int XLEN = 32
);
  logic                mem_req;
  logic                mem_we;
  logic [XLEN-1:0]     mem_addr;
  logic [XLEN-1:0]     mem_wdata;
  logic [XLEN/8-1:0]   mem_wstrb;
  logic                mem_ack;
  logic [XLEN-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/ins_exec_div.sv
// rtl/ins_exec_div.sv - iterative restoring divider with start/done handshake
module ins_exec_div #(
  parameter int XLEN           = 32,
  parameter int DIV_RADIX_BITS = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int ITERS = XLEN / DIV_RADIX_BITS;
  localparam int CW    = $clog2(ITERS + 1);

  logic [XLEN-1:0] rem_q, quo_q, dvs_q, rem_nx, quo_nx, a_mag, b_mag;
  logic [XLEN:0]   trial;
  logic [CW-1:0]   cnt_q;
  logic            busy_q, done_q, qneg_q, rneg_q, a_neg, b_neg, div0, ovf;

  // operand magnitudes and the two cases resolved without iterating
  always_comb begin
    a_neg = is_signed & dividend[XLEN-1];
    b_neg = is_signed & divisor[XLEN-1];
    a_mag = a_neg ? -dividend : dividend;
    b_mag = b_neg ? -divisor : divisor;
    div0  = (divisor == '0);
    ovf   = is_signed && (dividend == {1'b1, {(XLEN-1){1'b0}}}) && (divisor == '1);
  end

  // DIV_RADIX_BITS restoring steps per cycle; quo_q shifts the dividend out as quotient bits shift in
  always_comb begin
    rem_nx = rem_q;
    quo_nx = quo_q;
    trial  = '0;
    for (int i = 0; i < DIV_RADIX_BITS; i++) begin
      trial = {rem_nx, quo_nx[XLEN-1]} - {1'b0, dvs_q};
      if (!trial[XLEN]) begin
        rem_nx = trial[XLEN-1:0];
        quo_nx = {quo_nx[XLEN-2:0], 1'b1};
      end else begin
        rem_nx = {rem_nx[XLEN-2:0], quo_nx[XLEN-1]};
        quo_nx = {quo_nx[XLEN-2:0], 1'b0};
      end
    end
  end

  // load on start, iterate while busy, single-cycle done after the last step
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        dvs_q  <= b_mag;
        qneg_q <= 1'b0;
        rneg_q <= 1'b0;
        if (div0) begin
          quo_q  <= '1;
          rem_q  <= dividend;
          done_q <= 1'b1;
        end else if (ovf) begin
          quo_q  <= dividend;
          rem_q  <= '0;
          done_q <= 1'b1;
        end else begin
          quo_q  <= a_mag;
          rem_q  <= '0;
          qneg_q <= a_neg ^ b_neg;
          rneg_q <= a_neg;
          cnt_q  <= CW'(ITERS);
          busy_q <= 1'b1;
        end
      end else if (busy_q) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done      = done_q;
  assign quotient  = qneg_q ? -quo_q : quo_q;
  assign remainder = rneg_q ? -rem_q : rem_q;
endmodule

// File: rtl/ins_exec_mc.sv
// rtl/ins_exec_mc.sv - multi-cycle RV32I/M execute stage
module ins_exec_mc
  import ins_exec_mc_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ENABLE_M       = 1,
  parameter int DIV_RADIX_BITS = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       ins_dec_op,
  input  logic [2:0]       ins_dec_funct3,
  input  logic [6:0]       ins_dec_funct7,
  input  logic [XLEN-1:0]  reg_rs1_val,
  input  logic [XLEN-1:0]  reg_rs2_val,
  input  logic [XLEN-1:0]  reg_pc_val,
  input  logic [XLEN-1:0]  imm_ext_ext,
  input  logic [4:0]       reg_rd,
  ins_exec_mc_if.master    dmem,
  output logic             reg_w_op,
  output logic [4:0]       reg_w_reg_idx,
  output logic [XLEN-1:0]  reg_w_reg_val,
  output logic             reg_pc_w_op,
  output logic [XLEN-1:0]  reg_pc_w_val,
  output logic             exc_op,
  output logic [1:0]       exc_cause
);
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_MEM  = ST_MEM;
  localparam logic [1:0] S_DIV  = ST_DIV;
  localparam logic [1:0] S_WB   = ST_WB;
  localparam int LB = $clog2(XLEN / 8);
  localparam int SW = XLEN / 8;
  localparam int DW = 2 * XLEN;

  logic [1:0]      state;
  logic [6:0]      op_q, f7_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] rs1_q, rs2_q, pc_q, imm_q, addr_q, res_q;
  logic            exc_q;
  exc_cause_e      cause_q, in_cause;

  logic [XLEN-1:0] in_addr, opb, alu, ld_sh, ld_val, div_quo, div_rem;
  logic [DW-1:0]   mul_a, mul_b, prod;
  logic [SW-1:0]   strb;
  logic [LB-1:0]   off;
  logic [4:0]      shamt;
  logic            in_store, in_mem, in_div, in_illegal, in_misalign, div_start, div_done;
  logic            taken, use_res, wb, mem_st;

  assign in_ready  = (state == S_IDLE);
  assign div_start = in_ready && in_valid && in_div;

  // classify the offered instruction so IDLE can pick its next state
  always_comb begin
    in_addr  = reg_rs1_val + imm_ext_ext;
    in_store = (ins_dec_op == OP_STORE);
    in_mem   = (ins_dec_op == OP_LOAD) || in_store;
    in_div   = (ENABLE_M != 0) && (ins_dec_op == OP_R) && (ins_dec_funct7 == F7_MULDIV) && ins_dec_funct3[2];
    case (ins_dec_op)
      OP_R:      in_illegal = !((ins_dec_funct7 == F7_BASE) ||
                                ((ins_dec_funct7 == F7_ALT) && (ins_dec_funct3 == F3_ADD || ins_dec_funct3 == F3_SR)) ||
                                ((ENABLE_M != 0) && (ins_dec_funct7 == F7_MULDIV)));
      OP_I_COMP: in_illegal = ((ins_dec_funct3 == F3_SLL) && (ins_dec_funct7 != F7_BASE)) ||
                              ((ins_dec_funct3 == F3_SR) && (ins_dec_funct7 != F7_BASE) && (ins_dec_funct7 != F7_ALT));
      OP_LOAD:   in_illegal = (ins_dec_funct3 == 3'd3) || (ins_dec_funct3[2:1] == 2'b11);
      OP_STORE:  in_illegal = ins_dec_funct3[2] || (ins_dec_funct3 == 3'd3);
      OP_BRANCH: in_illegal = (ins_dec_funct3[2:1] == 2'b01);
      OP_JALR:   in_illegal = (ins_dec_funct3 != 3'd0);
      OP_JAL, OP_LUI, OP_AUIPC: in_illegal = 1'b0;
      default:   in_illegal = 1'b1;
    endcase
    in_misalign = in_mem && !in_illegal &&
                  (((ins_dec_funct3[1:0] == 2'b01) && in_addr[0]) ||
                   ((ins_dec_funct3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00)));
    in_cause = in_illegal ? EXC_ILLEGAL : (in_store ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN);
  end

  // FSM plus operand capture on acceptance and result capture for multi-cycle ops
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state   <= S_IDLE;
      op_q    <= '0;
      f3_q    <= '0;
      f7_q    <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      addr_q  <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      cause_q <= EXC_ILLEGAL;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_q    <= ins_dec_op;
          f3_q    <= ins_dec_funct3;
          f7_q    <= ins_dec_funct7;
          rd_q    <= reg_rd;
          rs1_q   <= reg_rs1_val;
          rs2_q   <= reg_rs2_val;
          pc_q    <= reg_pc_val;
          imm_q   <= imm_ext_ext;
          addr_q  <= in_addr;
          exc_q   <= in_illegal || in_misalign;
          cause_q <= in_cause;
          if (in_illegal || in_misalign) state <= S_WB;
          else if (in_mem)               state <= S_MEM;
          else if (in_div)               state <= S_DIV;
          else                           state <= S_WB;
        end
        S_MEM: if (dmem.mem_ack) begin
          res_q <= ld_val;
          state <= S_WB;
        end
        S_DIV: if (div_done) begin
          res_q <= f3_q[1] ? div_rem : div_quo;
          state <= S_WB;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  ins_exec_div #(
    .XLEN           (XLEN),
    .DIV_RADIX_BITS (DIV_RADIX_BITS)
  ) u_div (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .start     (div_start),
    .is_signed (!ins_dec_funct3[0]),
    .dividend  (reg_rs1_val),
    .divisor   (reg_rs2_val),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // single-cycle ALU, multiplier and branch compare on captured operands
  always_comb begin
    opb   = (op_q == OP_R) ? rs2_q : imm_q;
    shamt = opb[4:0];
    mul_a = (f3_q == F3_MULHU) ? DW'(rs1_q) : DW'($signed(rs1_q));
    mul_b = (f3_q == F3_MULHU || f3_q == F3_MULHSU) ? DW'(rs2_q) : DW'($signed(rs2_q));
    prod  = mul_a * mul_b;
    alu   = '0;
    case (op_q)
      OP_R, OP_I_COMP:
        if (op_q == OP_R && f7_q == F7_MULDIV) alu = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[DW-1:XLEN];
        else case (f3_q)
          F3_ADD:  alu = (op_q == OP_R && f7_q[5]) ? rs1_q - opb : rs1_q + opb;
          F3_SLL:  alu = rs1_q << shamt;
          F3_SLT:  alu = XLEN'($signed(rs1_q) < $signed(opb));
          F3_SLTU: alu = XLEN'(rs1_q < opb);
          F3_XOR:  alu = rs1_q ^ opb;
          F3_SR:   alu = f7_q[5] ? XLEN'($signed(rs1_q) >>> shamt) : rs1_q >> shamt;
          F3_OR:   alu = rs1_q | opb;
          default: alu = rs1_q & opb;
        endcase
      OP_LUI:          alu = imm_q;
      OP_AUIPC:        alu = pc_q + imm_q;
      OP_JAL, OP_JALR: alu = pc_q + XLEN'(4);
      default:         alu = '0;
    endcase
    case (f3_q)
      F3_BEQ:  taken = (rs1_q == rs2_q);
      F3_BNE:  taken = (rs1_q != rs2_q);
      F3_BLT:  taken = ($signed(rs1_q) < $signed(rs2_q));
      F3_BGE:  taken = ($signed(rs1_q) >= $signed(rs2_q));
      F3_BLTU: taken = (rs1_q < rs2_q);
      F3_BGEU: taken = (rs1_q >= rs2_q);
      default: taken = 1'b0;
    endcase
  end

  // memory request driven from captured address; load lane extraction on ack
  always_comb begin
    mem_st = (state == S_MEM);
    off    = addr_q[LB-1:0];
    case (f3_q[1:0])
      2'b00:   strb = SW'(4'b0001);
      2'b01:   strb = SW'(4'b0011);
      default: strb = SW'(4'b1111);
    endcase
    dmem.mem_req   = mem_st;
    dmem.mem_we    = mem_st && (op_q == OP_STORE);
    dmem.mem_addr  = mem_st ? {addr_q[XLEN-1:LB], {LB{1'b0}}} : '0;
    dmem.mem_wstrb = dmem.mem_we ? (strb << off) : '0;
    dmem.mem_wdata = dmem.mem_we ? (rs2_q << {off, 3'b000}) : '0;
    ld_sh = dmem.mem_rdata >> {off, 3'b000};
    case (f3_q)
      F3_LB:   ld_val = XLEN'($signed(ld_sh[7:0]));
      F3_LH:   ld_val = XLEN'($signed(ld_sh[15:0]));
      F3_LBU:  ld_val = XLEN'(ld_sh[7:0]);
      F3_LHU:  ld_val = XLEN'(ld_sh[15:0]);
      default: ld_val = XLEN'($signed(ld_sh[31:0]));
    endcase
  end

  // writeback pulses, held at zero outside the WB cycle
  always_comb begin
    wb            = (state == S_WB);
    use_res       = (op_q == OP_LOAD) || ((op_q == OP_R) && (f7_q == F7_MULDIV) && f3_q[2]);
    reg_w_op      = wb && !exc_q && (rd_q != 5'd0) && (op_q != OP_STORE) && (op_q != OP_BRANCH);
    reg_w_reg_idx = reg_w_op ? rd_q : 5'd0;
    reg_w_reg_val = reg_w_op ? (use_res ? res_q : alu) : '0;
    reg_pc_w_op   = wb && !exc_q && ((op_q == OP_JAL) || (op_q == OP_JALR) || ((op_q == OP_BRANCH) && taken));
    reg_pc_w_val  = !reg_pc_w_op ? '0 :
                    (op_q == OP_JALR) ? {addr_q[XLEN-1:1], 1'b0} : pc_q + imm_q;
    exc_op        = wb && exc_q;
    exc_cause     = exc_op ? cause_q : 2'd0;
  end
endmodule

// File: tb/tb_ins_exec_mc.sv
// tb/tb_ins_exec_mc.sv - directed self-checking bench for ins_exec_mc
module tb_ins_exec_mc;
  import ins_exec_mc_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  ins_dec_op = '0;
  logic [2:0]  ins_dec_funct3 = '0;
  logic [6:0]  ins_dec_funct7 = '0;
  logic [31:0] reg_rs1_val = '0, reg_rs2_val = '0, reg_pc_val = '0, imm_ext_ext = '0;
  logic [4:0]  reg_rd = '0;
  logic        reg_w_op, reg_pc_w_op, exc_op;
  logic [4:0]  reg_w_reg_idx;
  logic [31:0] reg_w_reg_val, reg_pc_w_val;
  logic [1:0]  exc_cause;

  int n_checks = 0;
  int n_pass = 0;

  ins_exec_mc_if #(.XLEN(32)) dmem_if ();

  ins_exec_mc #(.XLEN(32), .ENABLE_M(1), .DIV_RADIX_BITS(1)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .ins_dec_op     (ins_dec_op),
    .ins_dec_funct3 (ins_dec_funct3),
    .ins_dec_funct7 (ins_dec_funct7),
    .reg_rs1_val    (reg_rs1_val),
    .reg_rs2_val    (reg_rs2_val),
    .reg_pc_val     (reg_pc_val),
    .imm_ext_ext    (imm_ext_ext),
    .reg_rd         (reg_rd),
    .dmem           (dmem_if),
    .reg_w_op       (reg_w_op),
    .reg_w_reg_idx  (reg_w_reg_idx),
    .reg_w_reg_val  (reg_w_reg_val),
    .reg_pc_w_op    (reg_pc_w_op),
    .reg_pc_w_val   (reg_pc_w_val),
    .exc_op         (exc_op),
    .exc_cause      (exc_cause)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [4:0] rd);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    check("issue_ready", 64'(in_ready), 64'd1);
    ins_dec_op = op; ins_dec_funct3 = f3; ins_dec_funct7 = f7;
    reg_rs1_val = rs1; reg_rs2_val = rs2; reg_pc_val = pc; imm_ext_ext = imm; reg_rd = rd;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_wb(output int n);
    n = 1;
    while (!reg_w_op && n < 100) begin
      step();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    dmem_if.mem_ack = 1'b0;
    dmem_if.mem_rdata = '0;
    step(); step();
    sys_rst_n = 1'b1;
    step();
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_req", 64'(dmem_if.mem_req), 64'd0);
    check("rst_wop", 64'({reg_w_op, reg_pc_w_op, exc_op}), 64'd0);

    issue(OP_R, F3_ADD, F7_BASE, 32'h7FFFFFFF, 32'd1, 32'h0, 32'h0, 5'd5);
    check("add_wop", 64'(reg_w_op), 64'd1);
    check("add_idx", 64'(reg_w_reg_idx), 64'd5);
    check("add_val", 64'(reg_w_reg_val), 64'h80000000);
    check("add_wb_notready", 64'(in_ready), 64'd0);
    issue(OP_R, F3_ADD, F7_BASE, 32'h7FFFFFFF, 32'd1, 32'h0, 32'h0, 5'd0);
    check("add_x0_wop", 64'(reg_w_op), 64'd0);
    check("add_x0_val", 64'(reg_w_reg_val), 64'd0);

    issue(OP_I_COMP, F3_SR, F7_ALT, 32'h80000000, 32'h0, 32'h0, 32'h00000404, 5'd3);
    check("srai_val", 64'(reg_w_reg_val), 64'hF8000000);

    issue(OP_R, F3_MULHU, F7_MULDIV, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd4);
    check("mulhu_val", 64'(reg_w_reg_val), 64'hFFFFFFFE);
    issue(OP_R, F3_MULH, F7_MULDIV, 32'h80000000, 32'd2, 32'h0, 32'h0, 5'd4);
    check("mulh_val", 64'(reg_w_reg_val), 64'hFFFFFFFF);

    issue(OP_LOAD, F3_LB, F7_BASE, 32'h100, 32'h0, 32'h0, 32'd3, 5'd6);
    for (int i = 0; i < 3; i++) begin
      check("lb_req", 64'(dmem_if.mem_req), 64'd1);
      check("lb_addr", 64'(dmem_if.mem_addr), 64'h100);
      if (i == 2) begin
        dmem_if.mem_ack = 1'b1;
        dmem_if.mem_rdata = 32'h80FF0000;
      end
      step();
    end
    dmem_if.mem_ack = 1'b0;
    check("lb_wop", 64'(reg_w_op), 64'd1);
    check("lb_val", 64'(reg_w_reg_val), 64'hFFFFFF80);
    check("lb_req_drop", 64'(dmem_if.mem_req), 64'd0);

    issue(OP_LOAD, F3_LBU, F7_BASE, 32'h100, 32'h0, 32'h0, 32'd3, 5'd6);
    dmem_if.mem_ack = 1'b1;
    step();
    dmem_if.mem_ack = 1'b0;
    check("lbu_val", 64'(reg_w_reg_val), 64'h00000080);

    issue(OP_STORE, F3_SH, F7_BASE, 32'h200, 32'h1234, 32'h0, 32'd2, 5'd0);
    check("sh_we", 64'(dmem_if.mem_we), 64'd1);
    check("sh_addr", 64'(dmem_if.mem_addr), 64'h200);
    check("sh_strb", 64'(dmem_if.mem_wstrb), 64'b1100);
    check("sh_wdata", 64'(dmem_if.mem_wdata), 64'h12340000);
    dmem_if.mem_ack = 1'b1;
    step();
    dmem_if.mem_ack = 1'b0;
    check("sh_no_wop", 64'(reg_w_op), 64'd0);

    issue(OP_STORE, F3_SH, F7_BASE, 32'h200, 32'h1234, 32'h0, 32'd1, 5'd0);
    check("sh_mis_exc", 64'(exc_op), 64'd1);
    check("sh_mis_cause", 64'(exc_cause), 64'd2);
    check("sh_mis_req", 64'(dmem_if.mem_req), 64'd0);

    issue(OP_R, F3_ADD, 7'h7F, 32'd1, 32'd1, 32'h0, 32'h0, 5'd5);
    check("illegal_exc", 64'({exc_op, exc_cause}), 64'b100);
    check("illegal_wop", 64'(reg_w_op), 64'd0);

    issue(OP_R, F3_DIV, F7_MULDIV, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 5'd10);
    wait_wb(n);
    check("div_latency", 64'(n), 64'd34);
    check("div_val", 64'(reg_w_reg_val), 64'hFFFFFFFD);
    issue(OP_R, F3_REM, F7_MULDIV, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 5'd10);
    wait_wb(n);
    check("rem_val", 64'(reg_w_reg_val), 64'hFFFFFFFF);
    issue(OP_R, F3_DIVU, F7_MULDIV, 32'd5, 32'd0, 32'h0, 32'h0, 5'd10);
    wait_wb(n);
    check("divu0_latency", 64'(n), 64'd2);
    check("divu0_val", 64'(reg_w_reg_val), 64'hFFFFFFFF);
    issue(OP_R, F3_DIV, F7_MULDIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd10);
    wait_wb(n);
    check("divovf_latency", 64'(n), 64'd2);
    check("divovf_val", 64'(reg_w_reg_val), 64'h80000000);

    issue(OP_BRANCH, F3_BEQ, F7_BASE, 32'd9, 32'd9, 32'h40, 32'hFFFFFFF8, 5'd0);
    check("beq_pcop", 64'(reg_pc_w_op), 64'd1);
    check("beq_pc", 64'(reg_pc_w_val), 64'h38);
    issue(OP_BRANCH, F3_BNE, F7_BASE, 32'd9, 32'd9, 32'h40, 32'hFFFFFFF8, 5'd0);
    check("bne_nt", 64'({reg_pc_w_op, reg_w_op, reg_pc_w_val}), 64'd0);
    issue(OP_JALR, 3'd0, F7_BASE, 32'h101, 32'h0, 32'h40, 32'h0, 5'd1);
    check("jalr_pc", 64'(reg_pc_w_val), 64'h100);
    check("jalr_rd", 64'(reg_w_reg_val), 64'h44);

    issue(OP_R, F3_DIV, F7_MULDIV, 32'd100, 32'd3, 32'h0, 32'h0, 5'd10);
    for (int i = 0; i < 9; i++) step();
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    check("rstdiv_req", 64'(dmem_if.mem_req), 64'd0);
    check("rstdiv_ready", 64'(in_ready), 64'd1);
    check("rstdiv_pulses", 64'({reg_w_op, reg_pc_w_op, exc_op}), 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      pulses += int'(reg_w_op);
    end
    check("rstdiv_no_late_wb", 64'(pulses), 64'd0);

    issue(OP_LOAD, F3_LW, F7_BASE, 32'h300, 32'h0, 32'h0, 32'h0, 5'd8);
    check("rstmem_req_before", 64'(dmem_if.mem_req), 64'd1);
    step();
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    check("rstmem_req", 64'(dmem_if.mem_req), 64'd0);
    check("rstmem_ready", 64'(in_ready), 64'd1);
    check("rstmem_pulses", 64'({reg_w_op, reg_pc_w_op, exc_op}), 64'd0);
    dmem_if.mem_ack = 1'b1;
    dmem_if.mem_rdata = 32'hDEADBEEF;
    step();
    dmem_if.mem_ack = 1'b0;
    check("late_ack_wop", 64'(reg_w_op), 64'd0);
    check("late_ack_ready", 64'(in_ready), 64'd1);

    issue(OP_R, F3_ADD, F7_BASE, 32'd3, 32'd4, 32'h0, 32'h0, 5'd7);
    check("post_rst_add", 64'({reg_w_op, reg_w_reg_idx, reg_w_reg_val}), {1'b1, 5'd7, 32'd7});

    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
